// File: rtl/div_arbiter.sv
// div_arbiter: shares one fixed-latency pipelined divider among NUM_REQ requesters.
// Arbitrates requests, registers the winning operands into the divider, tracks
// in-flight tags and routes each quotient back as a one-cycle one-hot pulse.
// A zero denominator is replaced by the safe operands 0/1 and flagged as dbz.
// Build macro DIV_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// with no pointer register; without it, arbitration is round-robin.
module div_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int NUMER_W     = 24,
   parameter int DENOM_W     = 16,
   parameter int DIV_LATENCY = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*NUMER_W-1:0] req_numer,
   input  logic [NUM_REQ*DENOM_W-1:0] req_denom,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       div_clr,
   output logic [NUMER_W-1:0]         div_numer,
   output logic [DENOM_W-1:0]         div_denom,
   input  logic [NUMER_W-1:0]         div_quotient,
   output logic [NUM_REQ-1:0]         resp_valid,
   output logic [NUMER_W-1:0]         resp_quotient,
   output logic                       resp_dbz,
   output logic                       busy
);

   localparam int ID_W = $clog2(NUM_REQ);

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic            dbz;
   } tag_t;

   logic               grant_vld;
   logic [ID_W-1:0]    grant_id;
   logic               xfer;
   logic [NUMER_W-1:0] sel_numer;
   logic [DENOM_W-1:0] sel_denom;
   logic [NUMER_W-1:0] div_numer_q, div_numer_d;
   logic [DENOM_W-1:0] div_denom_q, div_denom_d;
   tag_t               tag_d;
   tag_t               tag_q [DIV_LATENCY];
   tag_t               resp_q;

`ifdef DIV_ARB_FIXED_PRIO_EN
   // Fixed priority: the lowest-index asserting requester wins.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            grant_vld = 1'b1;
            grant_id  = ID_W'(i);
         end
      end
   end
`else
   logic [ID_W-1:0] ptr_q, ptr_d;

   // Round-robin: search from the pointer upward with wrap; the smallest offset wins.
   always_comb begin
      logic [ID_W:0] idx;
      grant_vld = 1'b0;
      grant_id  = '0;
      idx       = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         idx = {1'b0, ptr_q} + (ID_W+1)'(off);
         if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
         if (req_valid[idx[ID_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_id  = idx[ID_W-1:0];
         end
      end
   end

   // Pointer moves past the granted requester; it holds when nothing is granted.
   always_comb begin
      ptr_d = ptr_q;
      if (xfer) ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
   end

   // Pointer register, back to requester 0 on reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
`endif

   // One-hot grant, suppressed while reset is asserted.
   always_comb begin
      xfer = grant_vld & ~rst;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = xfer && (grant_id == ID_W'(i));
      end
   end

   // Issue stage: pick the winner's operands, substitute 0/1 on a zero denominator.
   always_comb begin
      sel_numer   = req_numer[grant_id*NUMER_W +: NUMER_W];
      sel_denom   = req_denom[grant_id*DENOM_W +: DENOM_W];
      div_numer_d = div_numer_q;
      div_denom_d = div_denom_q;
      tag_d       = '0;
      if (xfer) begin
         tag_d.valid = 1'b1;
         tag_d.id    = grant_id;
         tag_d.dbz   = (sel_denom == '0);
         if (sel_denom == '0) begin
            div_numer_d = '0;
            div_denom_d = DENOM_W'(1);
         end else begin
            div_numer_d = sel_numer;
            div_denom_d = sel_denom;
         end
      end
   end

   // Operand registers, tag pipeline aligned with the divider, and the response stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_numer_q <= '0;
         div_denom_q <= DENOM_W'(1);
         // NOTE: the tag array is reset because its valid bits decide whether a response fires; a data-only array would not need it.
         for (int i = 0; i < DIV_LATENCY; i++) tag_q[i] <= '0;
         resp_q      <= '0;
      end else begin
         div_numer_q <= div_numer_d;
         div_denom_q <= div_denom_d;
         tag_q[0]    <= tag_d;
         for (int i = 1; i < DIV_LATENCY; i++) tag_q[i] <= tag_q[i-1];
         resp_q      <= tag_q[DIV_LATENCY-1];
      end
   end

   // Response decode: the quotient is valid in the cycle the tag reaches the response stage.
   always_comb begin
      busy = resp_q.valid;
      for (int i = 0; i < DIV_LATENCY; i++) busy = busy | tag_q[i].valid;
      for (int i = 0; i < NUM_REQ; i++) begin
         resp_valid[i] = resp_q.valid && (resp_q.id == ID_W'(i));
      end
      resp_quotient = (resp_q.valid && !resp_q.dbz) ? div_quotient : '0;
      resp_dbz      = resp_q.valid & resp_q.dbz;
   end

   assign div_clr   = rst;
   assign div_numer = div_numer_q;
   assign div_denom = div_denom_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter with a behavioural pipelined divider.
// Single transactions come from a vector table; streams and mid-operation reset
// are hand-written sequences. Expected grants follow DIV_ARB_FIXED_PRIO_EN.
module tb_div_arbiter;

   localparam int NUM_REQ = 2;
   localparam int NUMER_W = 24;
   localparam int DENOM_W = 16;
   localparam int L       = 6;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ*NUMER_W-1:0] req_numer;
   logic [NUM_REQ*DENOM_W-1:0] req_denom;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       div_clr;
   logic [NUMER_W-1:0]         div_numer;
   logic [DENOM_W-1:0]         div_denom;
   logic [NUMER_W-1:0]         div_quotient;
   logic [NUM_REQ-1:0]         resp_valid;
   logic [NUMER_W-1:0]         resp_quotient;
   logic                       resp_dbz;
   logic                       busy;

   int n_cmp  = 0;
   int n_fail = 0;

   div_arbiter #(
      .NUM_REQ(NUM_REQ), .NUMER_W(NUMER_W), .DENOM_W(DENOM_W), .DIV_LATENCY(L)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_numer(req_numer), .req_denom(req_denom),
      .req_ready(req_ready), .div_clr(div_clr),
      .div_numer(div_numer), .div_denom(div_denom), .div_quotient(div_quotient),
      .resp_valid(resp_valid), .resp_quotient(resp_quotient), .resp_dbz(resp_dbz),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Behavioural divider: L register stages; all-ones on a zero denominator.
   logic [NUMER_W-1:0] dq_pipe [L];
   always @(posedge clk) begin
      dq_pipe[0] <= (div_denom == '0) ? '1 : NUMER_W'(div_numer / div_denom);
      for (int i = 1; i < L; i++) dq_pipe[i] <= dq_pipe[i-1];
   end
   assign div_quotient = dq_pipe[L-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 2 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      int                 id;
      logic [NUMER_W-1:0] numer;
      logic [DENOM_W-1:0] denom;
      logic [NUMER_W-1:0] exp_q;
      logic               exp_dbz;
      logic [NUMER_W-1:0] exp_dn;
      logic [DENOM_W-1:0] exp_dd;
   } vec_t;

   vec_t vecs [7];

   // Stream stimulus shared by run_stream.
   int                 s_len;
   logic [1:0]         s_valid [10];
   logic [1:0]         s_ready [10];
   logic [NUMER_W-1:0] s_n0 [10];
   logic [NUMER_W-1:0] s_n1 [10];
   logic [DENOM_W-1:0] s_d0 [10];
   logic [DENOM_W-1:0] s_d1 [10];
   logic [NUMER_W-1:0] s_q [10];

   // Drives s_len cycles of requests; grant g must answer in cycle g+L+1.
   task automatic run_stream(input string tag);
      for (int cyc = 0; cyc < s_len + L + 2; cyc++) begin
         int g;
         if (cyc < s_len) begin
            req_valid = s_valid[cyc];
            req_numer = {s_n1[cyc], s_n0[cyc]};
            req_denom = {s_d1[cyc], s_d0[cyc]};
         end else begin
            req_valid = '0;
         end
         #1;
         if (cyc < s_len) check($sformatf("%s_ready%0d", tag, cyc), 32'(req_ready), 32'(s_ready[cyc]));
         g = cyc - L - 1;
         if (g >= 0 && g < s_len) begin
            check($sformatf("%s_resp%0d", tag, g), 32'(resp_valid), 32'(s_ready[g]));
            check($sformatf("%s_q%0d", tag, g), 32'(resp_quotient), 32'(s_q[g]));
         end else if (g == s_len) begin
            check($sformatf("%s_quiet", tag), 32'(resp_valid), 32'd0);
         end
         tick();
      end
   endtask

   initial begin
      vecs[0] = '{0, 24'd1000,     16'd10,    24'd100,      1'b0, 24'd1000,     16'd10};
      vecs[1] = '{1, 24'd77,       16'd0,     24'd0,        1'b1, 24'd0,        16'd1};
      vecs[2] = '{1, 24'd16777215, 16'd1,     24'd16777215, 1'b0, 24'd16777215, 16'd1};
      vecs[3] = '{0, 24'd16777215, 16'd65535, 24'd256,      1'b0, 24'd16777215, 16'd65535};
      vecs[4] = '{1, 24'd12345,    16'd1000,  24'd12,       1'b0, 24'd12345,    16'd1000};
      vecs[5] = '{0, 24'd7,        16'd8,     24'd0,        1'b0, 24'd7,        16'd8};
      vecs[6] = '{0, 24'd0,        16'd0,     24'd0,        1'b1, 24'd0,        16'd1};

      rst = 1'b1; req_valid = '0; req_numer = '0; req_denom = '0;
      repeat (3) tick();
      check("clr_in_reset", 32'(div_clr), 32'd1);
      req_valid = '1;
      #1;
      check("ready_in_reset", 32'(req_ready), 32'd0);
      req_valid = '0;
      rst = 1'b0;
      #1;
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_q", 32'(resp_quotient), 32'd0);
      check("rst_resp_dbz", 32'(resp_dbz), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_div_numer", 32'(div_numer), 32'd0);
      check("rst_div_denom", 32'(div_denom), 32'd1);
      tick();

      // Single transactions from the vector table.
      for (int v = 0; v < 7; v++) begin
         logic [NUM_REQ-1:0] onehot;
         logic [NUM_REQ-1:0] early;
         onehot = '0;
         onehot[vecs[v].id] = 1'b1;
         early  = '0;
         req_numer = '0; req_denom = '0;
         req_numer[vecs[v].id*NUMER_W +: NUMER_W] = vecs[v].numer;
         req_denom[vecs[v].id*DENOM_W +: DENOM_W] = vecs[v].denom;
         req_valid = onehot;
         #1;
         check($sformatf("v%0d_ready", v), 32'(req_ready), 32'(onehot));
         check($sformatf("v%0d_idle", v), 32'(busy), 32'd0);
         tick();
         req_valid = '0;
         check($sformatf("v%0d_div_numer", v), 32'(div_numer), 32'(vecs[v].exp_dn));
         check($sformatf("v%0d_div_denom", v), 32'(div_denom), 32'(vecs[v].exp_dd));
         check($sformatf("v%0d_busy_start", v), 32'(busy), 32'd1);
         for (int c = 1; c < L + 1; c++) begin
            early = early | resp_valid;
            tick();
         end
         check($sformatf("v%0d_early", v), 32'(early), 32'd0);
         check($sformatf("v%0d_resp", v), 32'(resp_valid), 32'(onehot));
         check($sformatf("v%0d_q", v), 32'(resp_quotient), 32'(vecs[v].exp_q));
         check($sformatf("v%0d_dbz", v), 32'(resp_dbz), 32'(vecs[v].exp_dbz));
         check($sformatf("v%0d_busy_resp", v), 32'(busy), 32'd1);
         tick();
         check($sformatf("v%0d_after", v), 32'(resp_valid), 32'd0);
         check($sformatf("v%0d_after_q", v), 32'(resp_quotient), 32'd0);
         check($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);
      end

      // Both requesters contending for four cycles.
      do_reset();
      s_len = 4;
      for (int c = 0; c < 4; c++) begin
         s_n0[c] = 24'd90; s_d0[c] = 16'd9;
         s_n1[c] = 24'd50; s_d1[c] = 16'd5;
         s_q[c]  = 24'd10;
      end
`ifdef DIV_ARB_FIXED_PRIO_EN
      s_valid = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      s_ready = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
`else
      s_valid = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      s_ready = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
`endif
      run_stream("contend");

      // Single requester streaming ten operations: numer 10*(c+1)+3 over 10 gives c+1.
      do_reset();
      s_len = 10;
      for (int c = 0; c < 10; c++) begin
         s_valid[c] = 2'b01;
         s_ready[c] = 2'b01;
         s_n0[c] = NUMER_W'(10 * (c + 1) + 3); s_d0[c] = 16'd10;
         s_n1[c] = '0;                         s_d1[c] = '0;
         s_q[c]  = NUMER_W'(c + 1);
      end
      run_stream("single");

      // Reset three cycles after a grant to requester 0: response must vanish, pointer returns to 0.
      do_reset();
      req_numer = {24'd50, 24'd1000};
      req_denom = {16'd5, 16'd10};
      req_valid = 2'b01;
      tick();
      req_valid = '0;
      tick();
      tick();
      check("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      req_valid = 2'b11;
      #1;
      check("mid_ready_in_reset", 32'(req_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("mid_ready_after", 32'(req_ready), 32'b01);
      check("mid_busy_after", 32'(busy), 32'd0);
      check("mid_div_numer", 32'(div_numer), 32'd0);
      check("mid_div_denom", 32'(div_denom), 32'd1);
      req_valid = '0;
      begin
         logic [NUM_REQ-1:0] seen;
         seen = '0;
         for (int c = 0; c < L + 4; c++) begin
            seen = seen | resp_valid;
            tick();
         end
         check("mid_no_resp", 32'(seen), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one fixed-latency pipelined divider among NUM_REQ requesters, e.g. several centroid trackers and a speed estimator on the DE2 vision path.
- Arbitrates requests and registers the winning operands into the divider.
- Tracks in-flight tags and routes each quotient back to its requester with a one-cycle response pulse.
- Substitutes safe operands and flags divide-by-zero.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- NUMER_W, 24, numerator and quotient width
- DENOM_W, 16, denominator width
- DIV_LATENCY, 6, edges from divider input change to valid quotient (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_numer  in  NUM_REQ*NUMER_W  packed numerators, requester i at [i*NUMER_W +: NUMER_W]
- req_denom  in  NUM_REQ*DENOM_W  packed denominators, same packing
- req_ready  out  NUM_REQ  one-hot grant
- div_clr  out  1  divider aclr, equals rst
- div_numer  out  NUMER_W  registered divider numerator
- div_denom  out  DENOM_W  registered divider denominator
- div_quotient  in  NUMER_W  divider result
- resp_valid  out  NUM_REQ  one-hot response pulse
- resp_quotient  out  NUMER_W  shared response data
- resp_dbz  out  1  response came from a zero denominator
- busy  out  1  any operation in flight

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: req_ready=0, resp_valid=0, resp_quotient=0, resp_dbz=0, busy=0, div_numer=0, div_denom=1, round-robin pointer=0, tag pipeline cleared.
- Grant:
  - req_ready is combinational from req_valid and the pointer.
  - At most one bit is set, and only for an asserting requester.
  - All bits are 0 while rst=1.
- Handshake:
  - A transfer is req_valid[i] && req_ready[i] at a rising edge.
  - A requester holds valid and operands stable until granted.
  - A request is never dropped.
- Round-robin:
  - Search starts at the pointer.
  - After a grant to i, the pointer becomes (i+1) mod NUM_REQ.
  - With no grant, the pointer holds.
- Issue stage (edge k, transfer from i):
  - If denom≠0: div_numer←numer, div_denom←denom.
  - If denom=0: div_numer←0, div_denom←1, dbz bit set.
  - With no transfer, div_numer and div_denom hold their values. A bubble tag enters the pipeline.
- Tag pipeline: carries {valid, id, dbz} for exactly DIV_LATENCY issue slots, aligned with the divider.
- Response:
  - For a transfer at edge k, resp_valid[id]=1 for exactly the one cycle following edge k+DIV_LATENCY.
  - In that cycle: resp_quotient=div_quotient, or 0 if dbz. resp_dbz=dbz.
  - When resp_valid=0: resp_quotient=0 and resp_dbz=0.
- Back-to-back: one issue per cycle is sustained. Consecutive grants produce responses on consecutive cycles in issue order.
- No response backpressure: the requester must accept its pulse.
- busy=1 while any valid tag is in the pipeline.
- Reset mid-operation:
  - In-flight tags are discarded. No response is produced for them.
  - Requests pending at reset are re-arbitrated after release, starting from requester 0.
- Single requester: receives a grant every cycle its valid is high.
- Widths: operands pass through unmodified. No truncation inside the block.

Optional Feature:
- Macro: DIV_ARB_FIXED_PRIO_EN.
- When defined: fixed priority, lowest index wins. The pointer is not implemented.
- When undefined: round-robin as above.
- All other behaviour is identical in both modes.

Test Plan:
- Reset, then req_valid=01 with numer=1000, denom=10, grant at edge k -> resp_valid=01 in the cycle after k+6, resp_quotient=100, resp_dbz=0. busy is high from k+1 through that cycle.
- Both requesters held valid for 4 grants (r0 numer=90/denom=9, r1 numer=50/denom=5) -> grants alternate 01,10,01,10. Responses alternate on consecutive cycles with quotients 10,10,10,10 routed to the correct one-hot.
- Requester 1 sends denom=0, numer=77 -> div_numer=0, div_denom=1. Response has resp_quotient=0, resp_dbz=1, resp_valid=10.
- rst asserted 3 cycles after a grant -> no resp_valid for that request. After release, outputs match reset values and the pointer is back at 0.
- Single requester held valid for 10 cycles -> 10 grants and 10 consecutive responses, with no bubbles.
- With DIV_ARB_FIXED_PRIO_EN, both valid for 3 cycles -> grants 01,01,01. r1 is granted only after r0 drops valid.
